// File: rtl/io_port_peripheral.sv
// io_port_peripheral
//   External-side partner of the miniSRC CPU I/O ports.
//   - Input FIFO (DEPTH words) filled by the host, fed one word at a time into the CPU in-port
//     through a small IDLE -> PRESENT -> WAIT_ACK handshake FSM.
//   - Output capture: every change of outPortData becomes a one-cycle out_valid event, with the
//     captured value on out_data and a wrapping event counter on out_count.
//   - Run monitor: stop is a registered ~run; halted is sticky on a 1->0 transition of run.
// Ports:
//   clock, reset (async, active-low)
//   host_wr_valid/host_wr_data/host_wr_ready : host push interface
//   inPort_en/inPortDataIn/in_ack            : CPU in-port feed
//   outPortData/out_valid/out_data/out_count : CPU out-port capture
//   run/stop/halted                          : run monitor
//   fifo_level                               : current FIFO occupancy
module io_port_peripheral #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     host_wr_valid,
  input  logic [31:0]              host_wr_data,
  output logic                     host_wr_ready,
  output logic                     inPort_en,
  output logic [31:0]              inPortDataIn,
  input  logic                     in_ack,
  input  logic [31:0]              outPortData,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic [CNT_W-1:0]         out_count,
  input  logic                     run,
  output logic                     stop,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StPresent, StWaitAck} feed_state_e;

  // FIFO storage and bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full, push, pop;

  // Feed FSM
  feed_state_e   state_q;
  logic          in_port_en_q;
  logic [31:0]   in_port_data_q;

  // Output capture
  logic [31:0]      prev_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [CNT_W-1:0] out_count_q;

  // Run monitor
  logic run_d_q, stop_q, halted_q;

  // Ready comes from the registered level only, so a pop in this cycle does not free a slot
  // until the next cycle.
  assign full = (level_q == LW'(DEPTH));
  assign push = host_wr_valid & ~full;
  // The FSM only sits in WAIT_ACK while the head word is outstanding, so the FIFO is
  // guaranteed non-empty here; acks in any other state are ignored.
  assign pop  = (state_q == StWaitAck) & in_ack;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: only entries covered by level_q are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_wr_data;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of 2, so they wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Feed FSM with registered strobe and data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      in_port_en_q   <= 1'b0;
      in_port_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (level_q != '0) begin
            state_q        <= StPresent;
            in_port_en_q   <= 1'b1;
            in_port_data_q <= mem_q[rd_ptr_q];
          end
        end
        StPresent: begin
          state_q      <= StWaitAck;
          in_port_en_q <= 1'b0;
        end
        StWaitAck: begin
          if (in_ack) state_q <= StIdle;
        end
        default: begin
          state_q      <= StIdle;
          in_port_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Output capture: any difference from the previous sample is one event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      prev_q <= outPortData;
      if (outPortData != prev_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= outPortData;
        out_count_q <= out_count_q + CNT_W'(1);
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Run monitor
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_d_q  <= 1'b0;
      stop_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      run_d_q <= run;
      stop_q  <= ~run;
      if (run_d_q && !run) halted_q <= 1'b1;
    end
  end

  assign host_wr_ready = ~full;
  assign fifo_level    = level_q;
  assign inPort_en     = in_port_en_q;
  assign inPortDataIn  = in_port_data_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_count     = out_count_q;
  assign stop          = stop_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_io_port_peripheral.sv
module tb_io_port_peripheral;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 8;  // narrow counter so wrap is reachable quickly

  logic             clock;
  logic             reset;
  logic             host_wr_valid;
  logic [31:0]      host_wr_data;
  logic             host_wr_ready;
  logic             inPort_en;
  logic [31:0]      inPortDataIn;
  logic             in_ack;
  logic [31:0]      outPortData;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             run;
  logic             stop;
  logic             halted;
  logic [3:0]       fifo_level;

  io_port_peripheral #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_wr_ready (host_wr_ready),
    .inPort_en     (inPort_en),
    .inPortDataIn  (inPortDataIn),
    .in_ack        (in_ack),
    .outPortData   (outPortData),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_count     (out_count),
    .run           (run),
    .stop          (stop),
    .halted        (halted),
    .fifo_level    (fifo_level)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] model[$];  // words the host has handed over and the CPU has not yet consumed
  logic [31:0] seen[$];   // every word presented with inPort_en, in order
  int          acked = 0; // how many presented words have been acknowledged

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobes are recorded mid-cycle so the main thread never races with this process.
  always @(negedge clock) begin
    if (inPort_en === 1'b1) seen.push_back(inPortDataIn);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    host_wr_valid = 1'b0;
    host_wr_data = '0;
    in_ack = 1'b0;
    outPortData = '0;
    run = 1'b0;
    seen.delete();
    model.delete();
    acked = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [31:0] d);
    host_wr_valid = 1'b1;
    host_wr_data = d;
    if (host_wr_ready === 1'b1) model.push_back(d);
    tick();
    host_wr_valid = 1'b0;
  endtask

  // Wait (bounded) for an unacknowledged strobe, then ack it once the FSM is in WAIT_ACK.
  task automatic ack_one(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (seen.size() > acked) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      in_ack = 1'b1;
      tick();
      in_ack = 1'b0;
      acked++;
      if (model.size() > 0) model.delete(0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    host_wr_valid = 1'b0;
    host_wr_data = '0;
    in_ack = 1'b0;
    outPortData = '0;
    run = 1'b0;
    tick();
    checks++;
    if ({inPort_en, inPortDataIn, out_valid, out_data, out_count, stop, halted, fifo_level,
         host_wr_ready} !== {1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 4'h0, 1'b1})
      $display("FAIL reset_values: en=%b din=%h ov=%b od=%h oc=%h stop=%b halt=%b lvl=%0d rdy=%b",
               inPort_en, inPortDataIn, out_valid, out_data, out_count, stop, halted,
               fifo_level, host_wr_ready);
    else passes++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_feed();
    bit ok;
    apply_reset();
    push_word(32'h0000_0080);
    checks++;
    if (fifo_level !== 4'd1 || inPort_en !== 1'b0)
      $display("FAIL basic_after_push: lvl=%0d en=%b want lvl=1 en=0", fifo_level, inPort_en);
    else passes++;
    tick();
    checks++;
    if (inPort_en !== 1'b1 || inPortDataIn !== 32'h80)
      $display("FAIL basic_strobe: en=%b din=%h want en=1 din=00000080", inPort_en, inPortDataIn);
    else passes++;
    tick();
    checks++;
    if (inPort_en !== 1'b0 || inPortDataIn !== 32'h80)
      $display("FAIL basic_strobe_width: en=%b din=%h want en=0 din=00000080",
               inPort_en, inPortDataIn);
    else passes++;
    tick();
    ok = 1'b0;
    ack_one(ok);
    checks++;
    if (!ok || fifo_level !== 4'd0)
      $display("FAIL basic_pop: ok=%b lvl=%0d want ok=1 lvl=0", ok, fifo_level);
    else passes++;
    tick();
    tick();
    checks++;
    if (inPort_en !== 1'b0 || seen.size() != 1)
      $display("FAIL basic_no_extra_strobe: en=%b strobes=%0d want en=0 strobes=1",
               inPort_en, seen.size());
    else passes++;
  endtask

  // Runs right after test_basic_feed so the pointers start at 1 and wrap during the fill.
  task automatic test_full_fifo();
    bit ok;
    int base;
    base = seen.size();
    for (int i = 1; i <= DEPTH; i++) push_word(32'(i));
    checks++;
    if (fifo_level !== 4'(DEPTH) || host_wr_ready !== 1'b0)
      $display("FAIL full_level: lvl=%0d rdy=%b want lvl=%0d rdy=0",
               fifo_level, host_wr_ready, DEPTH);
    else passes++;
    push_word(32'h9);
    checks++;
    if (fifo_level !== 4'(DEPTH) || host_wr_ready !== 1'b0)
      $display("FAIL full_overflow: lvl=%0d rdy=%b want lvl=%0d rdy=0",
               fifo_level, host_wr_ready, DEPTH);
    else passes++;
    for (int i = 0; i < DEPTH; i++) begin
      ok = 1'b0;
      ack_one(ok);
      checks++;
      if (!ok) $display("FAIL full_strobe_timeout: word %0d got no strobe want strobe", i + 1);
      else passes++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (seen.size() <= base + i || seen[base + i] !== 32'(i + 1))
        $display("FAIL full_order[%0d]: got %h want %h", i,
                 (seen.size() > base + i) ? seen[base + i] : 32'hx, 32'(i + 1));
      else passes++;
    end
    tick();
    checks++;
    if (fifo_level !== 4'd0 || host_wr_ready !== 1'b1 || seen.size() != base + DEPTH)
      $display("FAIL full_drained: lvl=%0d rdy=%b strobes=%0d want lvl=0 rdy=1 strobes=%0d",
               fifo_level, host_wr_ready, seen.size() - base, DEPTH);
    else passes++;
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    logic [31:0] exp[$];
    apply_reset();
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (seen.size() > 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    // ack the head and push a fourth word on the same edge
    in_ack = 1'b1;
    host_wr_valid = 1'b1;
    host_wr_data = 32'h44;
    if (model.size() > 0) model.delete(0);
    model.push_back(32'h44);
    tick();
    in_ack = 1'b0;
    host_wr_valid = 1'b0;
    acked = 1;
    checks++;
    if (!ok || fifo_level !== 4'd3 || inPort_en !== 1'b0)
      $display("FAIL simul_level: ok=%b lvl=%0d en=%b want ok=1 lvl=3 en=0",
               ok, fifo_level, inPort_en);
    else passes++;
    tick();  // back-to-back: next word presented right after the edge following the ack
    checks++;
    if (inPort_en !== 1'b1 || inPortDataIn !== 32'h22)
      $display("FAIL back_to_back: en=%b din=%h want en=1 din=00000022", inPort_en, inPortDataIn);
    else passes++;
    for (int i = 0; i < 3; i++) ack_one(ok);
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen.size() <= i || seen[i] !== exp[i])
        $display("FAIL simul_order[%0d]: got %h want %h", i,
                 (seen.size() > i) ? seen[i] : 32'hx, exp[i]);
      else passes++;
    end
  endtask

  task automatic test_spurious_ack();
    bit ok;
    apply_reset();
    in_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fifo_level !== 4'd0 || inPort_en !== 1'b0)
        $display("FAIL spurious_idle: lvl=%0d en=%b want lvl=0 en=0", fifo_level, inPort_en);
      else passes++;
    end
    in_ack = 1'b0;
    // ack landing on the PRESENT edge must also be ignored
    push_word(32'hCAFE_0001);
    tick();
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    checks++;
    if (fifo_level !== 4'd1)
      $display("FAIL spurious_present: lvl=%0d want 1", fifo_level);
    else passes++;
    ack_one(ok);
    checks++;
    if (!ok || fifo_level !== 4'd0)
      $display("FAIL spurious_recover: ok=%b lvl=%0d want ok=1 lvl=0", ok, fifo_level);
    else passes++;
  endtask

  // Randomized host pushes with randomly delayed acks, checked against a queue model.
  task automatic test_random_feed();
    bit pending;
    int wait_cnt;
    bit v, ack_now, push_ok;
    logic [31:0] d;
    apply_reset();
    pending = 1'b0;
    wait_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (fifo_level !== 4'(model.size()) || host_wr_ready !== (model.size() != DEPTH))
        $display("FAIL rand_level@%0d: lvl=%0d rdy=%b want lvl=%0d rdy=%b", cyc, fifo_level,
                 host_wr_ready, model.size(), model.size() != DEPTH);
      else passes++;
      if (inPort_en === 1'b1) begin
        checks++;
        if (pending || model.size() == 0 || inPortDataIn !== model[0])
          $display("FAIL rand_strobe@%0d: din=%h pending=%b want din=%h pending=0", cyc,
                   inPortDataIn, pending, (model.size() > 0) ? model[0] : 32'hx);
        else passes++;
        pending = 1'b1;
        wait_cnt = $urandom_range(1, 3);
      end
      ack_now = 1'b0;
      if (pending) begin
        if (wait_cnt == 0) begin
          ack_now = 1'b1;
          pending = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      v = (cyc < 400) && ($urandom % 3 != 0);
      d = $urandom;
      push_ok = v && (model.size() != DEPTH);
      if (ack_now) model.delete(0);
      if (push_ok) model.push_back(d);
      host_wr_valid = v;
      host_wr_data = d;
      in_ack = ack_now;
      tick();
    end
    host_wr_valid = 1'b0;
    in_ack = 1'b0;
    checks++;
    if (fifo_level !== 4'd0)
      $display("FAIL rand_drained: lvl=%0d want 0", fifo_level);
    else passes++;
  endtask

  task automatic test_output_capture();
    logic [31:0] prev, nv, exp_data;
    logic [CNT_W-1:0] exp_count;
    bit exp_valid;
    apply_reset();
    outPortData = 32'h55;
    tick();
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h55, 8'd1})
      $display("FAIL cap_first: ov=%b od=%h oc=%0d want 1 00000055 1", out_valid, out_data,
               out_count);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL cap_pulse_width: ov=%b want 0", out_valid);
    else passes++;
    tick();  // same value written again
    checks++;
    if (out_valid !== 1'b0 || out_count !== 8'd1)
      $display("FAIL cap_repeat: ov=%b oc=%0d want 0 1", out_valid, out_count);
    else passes++;
    outPortData = 32'hAA;
    tick();
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'hAA, 8'd2})
      $display("FAIL cap_second: ov=%b od=%h oc=%0d want 1 000000aa 2", out_valid, out_data,
               out_count);
    else passes++;
    prev = 32'hAA;
    exp_data = 32'hAA;
    exp_count = 8'd2;
    for (int i = 0; i < 300; i++) begin
      nv = ($urandom % 2 == 0) ? prev : $urandom;
      exp_valid = (nv != prev);
      if (exp_valid) begin
        exp_data = nv;
        exp_count = exp_count + 1'b1;
      end
      prev = nv;
      outPortData = nv;
      tick();
      checks++;
      if (out_valid !== exp_valid || out_data !== exp_data || out_count !== exp_count)
        $display("FAIL cap_rand@%0d: ov=%b od=%h oc=%0d want %b %h %0d", i, out_valid, out_data,
                 out_count, exp_valid, exp_data, exp_count);
      else passes++;
    end
    // keep changing until the model counter wraps to zero
    for (int i = 0; i < 300 && exp_count != 0; i++) begin
      prev = prev + 1;
      exp_count = exp_count + 1'b1;
      outPortData = prev;
      tick();
    end
    checks++;
    if (out_count !== 8'd0 || out_valid !== 1'b1 || out_data !== prev)
      $display("FAIL cap_wrap: oc=%0d ov=%b od=%h want 0 1 %h", out_count, out_valid, out_data,
               prev);
    else passes++;
  endtask

  task automatic test_run_monitor();
    bit exp_stop[5], exp_halt[5], runs[5];
    apply_reset();
    runs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_stop = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_halt = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run = runs[i];
      tick();
      checks++;
      if (stop !== exp_stop[i] || halted !== exp_halt[i])
        $display("FAIL run_step%0d: stop=%b halted=%b want %b %b", i, stop, halted,
                 exp_stop[i], exp_halt[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    outPortData = 32'h77;
    run = 1'b1;
    push_word(32'hDEAD_BEEF);
    run = 1'b0;
    tick();
    checks++;
    if (inPort_en !== 1'b1 || inPortDataIn !== 32'hDEAD_BEEF || halted !== 1'b1)
      $display("FAIL mid_present: en=%b din=%h halted=%b want 1 deadbeef 1",
               inPort_en, inPortDataIn, halted);
    else passes++;
    reset = 1'b0;
    outPortData = '0;
    #1;
    checks++;
    if ({inPort_en, inPortDataIn, out_valid, out_data, out_count, stop, halted, fifo_level,
         host_wr_ready} !== {1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 4'h0, 1'b1})
      $display("FAIL mid_reset_values: en=%b din=%h ov=%b od=%h oc=%h stop=%b halt=%b lvl=%0d rdy=%b",
               inPort_en, inPortDataIn, out_valid, out_data, out_count, stop, halted,
               fifo_level, host_wr_ready);
    else passes++;
    #1;
    reset = 1'b1;
    seen.delete();
    model.delete();
    acked = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (inPort_en !== 1'b0 || fifo_level !== 4'd0)
        $display("FAIL mid_discarded: en=%b lvl=%0d want 0 0", inPort_en, fifo_level);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_feed();
    test_full_fifo();
    test_simul_push_pop();
    test_spurious_ack();
    test_random_feed();
    test_output_capture();
    test_run_monitor();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
